// File: rtl/huff_pair_decoder.sv
// rtl/huff_pair_decoder.sv - bit-serial MP3 big-values Huffman pair decoder
//
// Purpose:
//   Consumes a serial bitstream one bit per handshake and decodes big-values
//   pairs using an external combinational codebook lookup. For each pair it
//   handles the escape/linbits extension and the sign bits, then presents a
//   signed (x, y) pair with ready/valid backpressure.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle start request, sampled only in IDLE
//   cfg_linbits       linbits for the region, latched on start
//   cfg_num_pairs     number of pairs to decode, latched on start
//   bit_valid/ready   serial bit handshake; bit_data is MSB-first
//   lut_code/lut_len  codeword candidate presented to the codebook
//   lut_hit/x/y       codebook response (combinational)
//   out_valid/ready   pair handshake; x_val/y_val are two's complement
//   done              one-cycle pulse after the last pair is accepted
//   err               one-cycle pulse on codeword overflow
//   busy              decoder is not idle
//   err_count         saturating overflow counter (HUFF_ERR_CNT_EN only)
//
// Optional feature macro: HUFF_ERR_CNT_EN

module huff_pair_decoder #(
    parameter int MAX_BITS    = 19,
    parameter int LINBITS_MAX = 13,
    parameter int ESC_VAL     = 15,
    parameter int OUT_W       = 16,
    parameter int CNT_W       = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          cfg_linbits,
    input  logic [CNT_W-1:0]    cfg_num_pairs,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                bit_ready,
    output logic [MAX_BITS-1:0] lut_code,
    output logic [4:0]          lut_len,
    input  logic                lut_hit,
    input  logic [3:0]          lut_x,
    input  logic [3:0]          lut_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    x_val,
    output logic [OUT_W-1:0]    y_val,
    output logic                done,
    output logic                err,
    output logic                busy
`ifdef HUFF_ERR_CNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_XLIN,
        S_XSIGN,
        S_YLIN,
        S_YSIGN,
        S_OUT
    } state_t;

    // The buffer only ever needs MAX_BITS-1 bits: the MAX_BITS-th bit is
    // either a hit or the overflow point, never stored.
    localparam int         BUF_W  = MAX_BITS - 1;
    localparam logic [3:0] ESC    = 4'(ESC_VAL);
    localparam logic [3:0] LB_MAX = 4'(LINBITS_MAX);
    localparam logic [4:0] LEN_LAST = 5'(MAX_BITS - 1);

    state_t                 state;
    logic [BUF_W-1:0]       code_buf;
    logic [4:0]             code_len;
    logic [3:0]             x_abs;
    logic [3:0]             y_abs;
    logic [LINBITS_MAX-1:0] linval_x;
    logic [LINBITS_MAX-1:0] linval_y;
    logic                   x_neg;
    logic [3:0]             lin_left;
    logic [3:0]             linbits;
    logic [CNT_W-1:0]       num_pairs;
    logic [CNT_W-1:0]       pair_cnt;

    logic                   take;
    logic                   code_ovf;
    logic [CNT_W-1:0]       pair_cnt_inc;
    state_t                 code_next;
    state_t                 xsign_next;

    // First applicable y stage for a given y abs value.
    function automatic state_t y_entry(input logic [3:0] ya, input logic [3:0] lb);
        if (ya == ESC && lb != 4'd0) begin
            return S_YLIN;
        end else if (ya != 4'd0) begin
            return S_YSIGN;
        end else begin
            return S_OUT;
        end
    endfunction

    // First applicable stage after a codeword hit. A zero x abs value can
    // never pick up linbits, so a zero abs value means a zero magnitude.
    function automatic state_t x_entry(input logic [3:0] xa, input logic [3:0] ya,
                                       input logic [3:0] lb);
        if (xa == ESC && lb != 4'd0) begin
            return S_XLIN;
        end else if (xa != 4'd0) begin
            return S_XSIGN;
        end else begin
            return y_entry(ya, lb);
        end
    endfunction

    // Unsigned magnitude abs+linval, then two's complement when negative.
    function automatic logic [OUT_W-1:0] signed_val(input logic [3:0] a,
                                                    input logic [LINBITS_MAX-1:0] lin,
                                                    input logic neg);
        logic [OUT_W-1:0] mag;
        mag = OUT_W'(a) + OUT_W'(lin);
        return neg ? (OUT_W'(0) - mag) : mag;
    endfunction

    assign bit_ready    = (state == S_CODE) || (state == S_XLIN) || (state == S_XSIGN) ||
                          (state == S_YLIN) || (state == S_YSIGN);
    assign busy         = (state != S_IDLE);
    assign take         = bit_valid && bit_ready;
    assign pair_cnt_inc = pair_cnt + 1'b1;
    assign code_next    = x_entry(lut_x, lut_y, linbits);
    assign xsign_next   = y_entry(y_abs, linbits);
    assign code_ovf     = (state == S_CODE) && take && !lut_hit && (code_len == LEN_LAST);

    // Codebook request: the bits collected so far with the incoming bit
    // appended. lut_len of zero tells the owner the request is idle.
    always_comb begin
        lut_code = '0;
        lut_len  = 5'd0;
        if (state == S_CODE && bit_valid) begin
            lut_code = {code_buf, bit_data};
            lut_len  = code_len + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            code_buf  <= '0;
            code_len  <= 5'd0;
            x_abs     <= 4'd0;
            y_abs     <= 4'd0;
            linval_x  <= '0;
            linval_y  <= '0;
            x_neg     <= 1'b0;
            lin_left  <= 4'd0;
            linbits   <= 4'd0;
            num_pairs <= '0;
            pair_cnt  <= '0;
            out_valid <= 1'b0;
            x_val     <= '0;
            y_val     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_num_pairs == '0) begin
                            done <= 1'b1;
                        end else begin
                            num_pairs <= cfg_num_pairs;
                            linbits   <= (cfg_linbits > LB_MAX) ? LB_MAX : cfg_linbits;
                            pair_cnt  <= '0;
                            code_buf  <= '0;
                            code_len  <= 5'd0;
                            linval_x  <= '0;
                            linval_y  <= '0;
                            x_neg     <= 1'b0;
                            state     <= S_CODE;
                        end
                    end
                end

                S_CODE: begin
                    if (take) begin
                        if (lut_hit) begin
                            x_abs    <= lut_x;
                            y_abs    <= lut_y;
                            code_buf <= '0;
                            code_len <= 5'd0;
                            lin_left <= linbits;
                            state    <= code_next;
                            // Only a (0,0) codeword reaches OUT directly.
                            if (code_next == S_OUT) begin
                                x_val     <= '0;
                                y_val     <= '0;
                                out_valid <= 1'b1;
                            end
                        end else if (code_ovf) begin
                            err      <= 1'b1;
                            code_buf <= '0;
                            code_len <= 5'd0;
                            state    <= S_IDLE;
                        end else begin
                            code_buf <= {code_buf[BUF_W-2:0], bit_data};
                            code_len <= code_len + 5'd1;
                        end
                    end
                end

                S_XLIN: begin
                    if (take) begin
                        linval_x <= {linval_x[LINBITS_MAX-2:0], bit_data};
                        lin_left <= lin_left - 4'd1;
                        if (lin_left == 4'd1) begin
                            state <= S_XSIGN;
                        end
                    end
                end

                S_XSIGN: begin
                    if (take) begin
                        x_neg    <= bit_data;
                        lin_left <= linbits;
                        state    <= xsign_next;
                        if (xsign_next == S_OUT) begin
                            x_val     <= signed_val(x_abs, linval_x, bit_data);
                            y_val     <= '0;
                            out_valid <= 1'b1;
                        end
                    end
                end

                S_YLIN: begin
                    if (take) begin
                        linval_y <= {linval_y[LINBITS_MAX-2:0], bit_data};
                        lin_left <= lin_left - 4'd1;
                        if (lin_left == 4'd1) begin
                            state <= S_YSIGN;
                        end
                    end
                end

                S_YSIGN: begin
                    if (take) begin
                        x_val     <= signed_val(x_abs, linval_x, x_neg);
                        y_val     <= signed_val(y_abs, linval_y, bit_data);
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pair_cnt  <= pair_cnt_inc;
                        if (pair_cnt_inc == num_pairs) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            linval_x <= '0;
                            linval_y <= '0;
                            x_neg    <= 1'b0;
                            state    <= S_CODE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HUFF_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 16'd0;
        end else if (code_ovf && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
